// File: rtl/car_request_conditioner_if.sv
// car_request_conditioner_if: sensor, light and request signals between the road loops, the light FSM and the conditioner.
interface car_request_conditioner_if;
   logic EWSensor;
   logic NSSensor;
   logic EWLite;
   logic NSLite;
   logic EWCar;
   logic NSCar;
   logic LiteErr;
   modport master (
      output EWSensor, NSSensor, EWLite, NSLite,
      input  EWCar, NSCar, LiteErr
   );
   modport slave (
      input  EWSensor, NSSensor, EWLite, NSLite,
      output EWCar, NSCar, LiteErr
   );
endinterface

// File: rtl/car_request_conditioner.sv
// car_request_conditioner: syncs, debounces and latches car sensors into requests gated by a minimum green time.
module car_request_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MIN_GREEN       = 8
) (
   input logic clock,
   input logic resetn,
   car_request_conditioner_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(MIN_GREEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TMR_DONE = TW'(MIN_GREEN);
   // bit 0 is east-west, bit 1 is north-south
   logic [1:0] raw, lite, meta, sync, filt, req;
   logic [CW-1:0] cnt [2];
   logic [TW-1:0] tmr;
   logic prev_lite, lite_err, illegal, done;
   assign raw     = {bus.NSSensor, bus.EWSensor};
   assign lite    = {bus.NSLite, bus.EWLite};
   assign illegal = bus.EWLite == bus.NSLite;
   assign done    = tmr == TMR_DONE;
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta      <= '0;
         sync      <= '0;
         filt      <= '0;
         req       <= '0;
         cnt[0]    <= '0;
         cnt[1]    <= '0;
         tmr       <= '0;
         prev_lite <= 1'b0;
         lite_err  <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= (sync[i] == filt[i] || cnt[i] == CNT_LAST) ? '0 : cnt[i] + 1'b1;
            if (sync[i] != filt[i] && cnt[i] == CNT_LAST) filt[i] <= sync[i];
            // serving clears the request even if the car is still present
            if (!illegal) req[i] <= lite[i] ? 1'b0 : (filt[i] | req[i]);
         end
         prev_lite <= bus.EWLite;
         tmr       <= (illegal || bus.EWLite != prev_lite) ? '0 : (done ? tmr : tmr + 1'b1);
         lite_err  <= lite_err | illegal;
      end
   end
   assign bus.EWCar   = req[0] & done;
   assign bus.NSCar   = req[1] & done;
   assign bus.LiteErr = lite_err;
endmodule

// File: tb/tb_car_request_conditioner.sv
// tb_car_request_conditioner: directed scenarios plus random sensor/light traffic against a window-based reference model.
module tb_car_request_conditioner;
   localparam int D = 4;
   localparam int G = 8;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   always #5 clock = ~clock;
   car_request_conditioner_if bus ();
   car_request_conditioner #(.DEBOUNCE_CYCLES(D), .MIN_GREEN(G)) dut (
      .clock(clock),
      .resetn(resetn),
      .bus(bus)
   );
   // reference: filter flips once the last D synced samples all disagree with it
   logic m_meta [2];
   logic m_s [2];
   logic m_filt [2];
   logic m_req [2];
   logic hist [2][$];
   logic m_prev, m_err;
   int since;
   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_meta[d] = 1'b0;
         m_s[d]    = 1'b0;
         m_filt[d] = 1'b0;
         m_req[d]  = 1'b0;
         hist[d].delete();
      end
      m_prev = 1'b0;
      m_err  = 1'b0;
      since  = 0;
   endtask
   task automatic model_edge();
      logic raw [2];
      logic lite [2];
      logic ill, bad;
      raw[0]  = bus.EWSensor;
      raw[1]  = bus.NSSensor;
      lite[0] = bus.EWLite;
      lite[1] = bus.NSLite;
      ill = bus.EWLite == bus.NSLite;
      for (int d = 0; d < 2; d++) begin
         if (!ill) m_req[d] = lite[d] ? 1'b0 : (m_filt[d] ? 1'b1 : m_req[d]);
         hist[d].push_back(m_s[d]);
         if (hist[d].size() > D) void'(hist[d].pop_front());
         bad = hist[d].size() == D;
         for (int j = 0; j < hist[d].size(); j++) if (hist[d][j] == m_filt[d]) bad = 1'b0;
         if (bad) begin
            m_filt[d] = ~m_filt[d];
            hist[d].delete();
         end
         m_s[d]    = m_meta[d];
         m_meta[d] = raw[d];
      end
      since  = (ill || bus.EWLite != m_prev) ? 0 : since + 1;
      m_prev = bus.EWLite;
      m_err  = m_err | ill;
   endtask
   task automatic step(input string tag);
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check({tag, "_ewcar"}, bus.EWCar, m_req[0] && since >= G);
      check({tag, "_nscar"}, bus.NSCar, m_req[1] && since >= G);
      check({tag, "_liteerr"}, bus.LiteErr, m_err);
   endtask
   task automatic set_lites(input logic ew, input logic ns);
      bus.EWLite = ew;
      bus.NSLite = ns;
   endtask
   task automatic release_and_wait_ew(input string tag);
      int first;
      first = -1;
      resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(tag);
         if (first < 0 && bus.EWCar) first = i;
         check({tag, "_ns_quiet"}, bus.NSCar, 1'b0);
      end
      check({tag, "_first_edge7"}, first == 7, 1'b1);
      check({tag, "_ew_held"}, bus.EWCar, 1'b1);
   endtask
   initial begin
      int ew_hold, ns_hold, lite_hold;
      logic seen;
      bus.EWSensor = 1'b1;
      bus.NSSensor = 1'b0;
      set_lites(1'b0, 1'b1);
      model_reset();
      repeat (3) @(negedge clock);
      check("reset_ewcar", bus.EWCar, 1'b0);
      check("reset_nscar", bus.NSCar, 1'b0);
      check("reset_liteerr", bus.LiteErr, 1'b0);
      release_and_wait_ew("clean");
      // asynchronous reset mid-stream, outputs must drop without a clock edge
      #2 resetn = 1'b0;
      #1;
      check("async_ewcar", bus.EWCar, 1'b0);
      check("async_nscar", bus.NSCar, 1'b0);
      check("async_liteerr", bus.LiteErr, 1'b0);
      model_reset();
      @(negedge clock);
      release_and_wait_ew("rerelease");
      // serve EW and let the filter fall so the bounce test starts clean
      bus.EWSensor = 1'b0;
      set_lites(1'b1, 1'b0);
      repeat (10) step("clear");
      set_lites(1'b0, 1'b1);
      repeat (10) step("settle");
      seen = 1'b0;
      repeat (5) begin
         bus.EWSensor = 1'b1;
         repeat (3) begin
            step("bounce");
            seen = seen | bus.EWCar;
         end
         bus.EWSensor = 1'b0;
         step("bounce");
         seen = seen | bus.EWCar;
      end
      check("bounce_never", seen, 1'b0);
      bus.EWSensor = 1'b1;
      repeat (4) step("hold4");
      bus.EWSensor = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         step("hold4");
         seen = seen | bus.EWCar;
      end
      check("hold4_asserts", seen, 1'b1);
      repeat (10) step("latched");
      check("latched_ew", bus.EWCar, 1'b1);
      bus.NSSensor = 1'b1;
      repeat (10) step("ns_served");
      check("ns_served_nscar", bus.NSCar, 1'b0);
      set_lites(1'b1, 1'b0);
      step("svc_t");
      check("svc_ew_drop", bus.EWCar, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         step("svc");
         if (i == 7) check("svc_ns_early", bus.NSCar, 1'b0);
         if (i == 9) check("svc_ns_by9", bus.NSCar, 1'b1);
      end
      set_lites(1'b1, 1'b1);
      step("illegal");
      check("illegal_err", bus.LiteErr, 1'b1);
      check("illegal_ns0", bus.NSCar, 1'b0);
      set_lites(1'b1, 1'b0);
      repeat (12) step("recover");
      check("recover_err_sticky", bus.LiteErr, 1'b1);
      check("recover_ns", bus.NSCar, 1'b1);
      ew_hold = 1;
      ns_hold = 1;
      lite_hold = 1;
      for (int i = 0; i < 3000; i++) begin
         if (--ew_hold == 0) begin
            bus.EWSensor = 1'($urandom_range(0, 1));
            ew_hold = $urandom_range(1, 7);
         end
         if (--ns_hold == 0) begin
            bus.NSSensor = 1'($urandom_range(0, 1));
            ns_hold = $urandom_range(1, 7);
         end
         if (--lite_hold == 0) begin
            if ($urandom_range(0, 29) == 0) begin
               bus.EWLite = 1'($urandom_range(0, 1));
               bus.NSLite = bus.EWLite;
               lite_hold = 1;
            end else begin
               bus.EWLite = 1'($urandom_range(0, 1));
               bus.NSLite = ~bus.EWLite;
               lite_hold = $urandom_range(3, 25);
            end
         end
         step("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
